// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the instruction fetch path: FSM encoding,
// reset PC and PC step.
package instr_fetch_pkg;

  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_EXEC  = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  // Word addresses always have the two byte-select bits cleared.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC generator: sequential step or PC-relative branch,
// all arithmetic modulo 2^32.
module pc_next
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] ext_imm_i,
  input  logic        pc_src_i,
  output logic [31:0] pc_next_o
);

  logic [31:0] br_ofs;
  logic [31:0] sum;

  // The shift drops ExtImm[31:30]; the offset stays word aligned.
  assign br_ofs    = pc_src_i ? (ext_imm_i << 2) : 32'd0;
  assign sum       = pc_i + PC_INC + br_ofs;
  assign pc_next_o = word_align(sum);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch controller: requests one word at PC, holds it for a
// single execute slot, then advances PC or parks in HALT.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FETCH | ImemReq high at PC, waiting for ImemAck (zero-wait allowed)
// ST_EXEC  | one cycle, InsValid high, PCWre/PCSrc sampled
// ST_HALT  | parked until Reset, no requests
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic        PCSrc,
  input  logic [31:0] ExtImm,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic        InsValid,
  output logic [31:0] Instruction,
  output logic [5:0]  OpCode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] Imm16,
  output logic [31:0] CurPC,
  output logic        Halted,
  output logic [31:0] InsCount
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cur_pc_q, cur_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_nxt;

  pc_next u_pc_next (
    .pc_i      (pc_q),
    .ext_imm_i (ExtImm),
    .pc_src_i  (PCSrc),
    .pc_next_o (pc_nxt)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cur_pc_d = cur_pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_FETCH: begin
        if (ImemAck) begin
          instr_d  = ImemData;
          cur_pc_d = pc_q;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q + 32'd1;
        if (PCWre) begin
          pc_d    = pc_nxt;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= PC_RESET;
      cur_pc_q <= PC_RESET;
      instr_q  <= 32'd0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= word_align(pc_d);
      cur_pc_q <= cur_pc_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Reset gates the request so memory sees nothing while it is held.
  assign ImemReq     = (state_q == ST_FETCH) && !Reset;
  assign ImemAddr    = word_align(pc_q);
  assign InsValid    = (state_q == ST_EXEC);
  assign Halted      = (state_q == ST_HALT);
  assign CurPC       = cur_pc_q;
  assign InsCount    = cnt_q;

  assign Instruction = instr_q;
  assign OpCode      = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign Imm16       = instr_q[15:0];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port PCWre, input, 1, PC write enable from control; 0 means halt.
REQ-004 SHALL have port PCSrc, input, 1, branch select from control; 1 means branch target.
REQ-005 SHALL have port ExtImm, input, 32, extended immediate of the current instruction.
REQ-006 SHALL have port ImemReq, output, 1, instruction memory read request.
REQ-007 SHALL have port ImemAddr, output, 32, byte address of the requested word.
REQ-008 SHALL have port ImemAck, input, 1, memory data-valid strobe.
REQ-009 SHALL have port ImemData, input, 32, instruction word; valid only when ImemAck=1.
REQ-010 SHALL have port InsValid, output, 1, the decoded outputs are valid this cycle (execute slot).
REQ-011 SHALL have port Instruction, output, 32, latched instruction word.
REQ-012 SHALL have port OpCode, output, 6, Instruction[31:26].
REQ-013 SHALL have ports rs/rt/rd, output, 5 each, Instruction[25:21]/[20:16]/[15:11].
REQ-014 SHALL have port Imm16, output, 16, Instruction[15:0].
REQ-015 SHALL have port CurPC, output, 32, address of the latched instruction.
REQ-016 SHALL have port Halted, output, 1, the block is in the HALT state.
REQ-017 SHALL have port InsCount, output, 32, count of executed instructions.

Function
REQ-018 SHALL implement the FSM states FETCH, EXEC and HALT.
REQ-019 FETCH: ImemReq=1 and ImemAddr=PC held stable until the ack; on ImemAck=1, capture ImemData into Instruction and CurPC<=PC, then go to EXEC.
REQ-020 An ack in the same cycle that the request first asserts SHALL be accepted (zero wait states); a fetch therefore takes a minimum of 1 cycle.
REQ-021 ImemAck SHALL be ignored outside FETCH.
REQ-022 EXEC lasts exactly one cycle with InsValid=1 and ImemReq=0; PCWre and PCSrc SHALL be sampled only in this cycle.
REQ-023 In EXEC with PCWre=1: PC<=PC+4 if PCSrc=0, else PC<=PC+4+(ExtImm<<2); the state returns to FETCH and InsCount increments.
REQ-024 In EXEC with PCWre=0: PC is held, the state goes to HALT and InsCount increments.
REQ-025 HALT: ImemReq=0, InsValid=0 and Halted=1; the block leaves HALT only on Reset.
REQ-026 PC arithmetic SHALL be modulo 2^32 with silent wrap (0xFFFFFFFC+4=0x00000000); ExtImm<<2 drops its top two bits.
REQ-027 PC[1:0] SHALL always be 00, and ImemAddr[1:0] SHALL always be 00.
REQ-028 InsCount SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 The decoded outputs SHALL be pure slices of the Instruction register and SHALL hold their value outside EXEC.

Reset
REQ-030 Reset=1 SHALL immediately force the state to FETCH, PC, CurPC, Instruction and InsCount to 0, and InsValid and Halted to 0.
REQ-031 While Reset=1, ImemReq SHALL be 0; the first request with ImemAddr=0 SHALL appear in the first cycle after deassertion.
REQ-032 A reset mid-fetch SHALL abandon the request; the memory SHALL drop any outstanding read on Reset.

Structure
REQ-033 The state encoding, the reset PC (32'h0) and the PC increment (4) SHALL live in the shared CPU package.
REQ-034 The next-PC adder/mux SHALL be one sub-module, pc_next, which is purely combinational; the FSM and registers belong in instr_fetch.

Verification
REQ-035 Reset released with a zero-wait memory -> ImemReq=1 and ImemAddr=0 in cycle 1, InsValid in cycle 2, and ImemAddr=4 in cycle 3.
REQ-036 Ack delayed by 3 cycles -> ImemAddr held at 0 for all 4 request cycles and Instruction captured only on the ack cycle.
REQ-037 EXEC at PC=0x10 with PCSrc=1 and ExtImm=0xFFFFFFFE -> next ImemAddr=0x0C; with ExtImm=3 -> 0x20.
REQ-038 PC=0xFFFFFFFC, PCSrc=0 -> next ImemAddr=0x00000000, and InsCount increments.
REQ-039 Opcode 6'b111111 word with PCWre=0 -> Halted=1 and ImemReq stays 0 for 20 cycles, with PC, CurPC and InsCount frozen.
REQ-040 Reset asserted during a delayed fetch at PC=0x8 -> outputs clear immediately, and the next fetch after release is from address 0.
